// File: rtl/rvh_l1d_amo_ctrl_if.sv
// rvh_l1d_amo_ctrl_if: request, data-array, ALU, write-back and response signals of the L1D AMO sequencer.
interface rvh_l1d_amo_ctrl_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [3:0]       req_amo_op_i;
    logic             req_is_w_i;
    logic             req_word_hi_i;
    logic [XLEN-1:0]  req_src_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             rd_req_valid_o;
    logic             rd_req_ready_i;
    logic             rd_resp_valid_i;
    logic [XLEN-1:0]  rd_resp_data_i;
    logic [3:0]       alu_opcode_o;
    logic             alu_op_w_o;
    logic [XLEN-1:0]  alu_operand0_o;
    logic [XLEN-1:0]  alu_operand1_o;
    logic [XLEN-1:0]  alu_result_i;
    logic             wr_valid_o;
    logic             wr_ready_i;
    logic [XLEN-1:0]  wr_data_o;
    logic [7:0]       wr_mask_o;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic [XLEN-1:0]  resp_data_o;
    logic [TAG_W-1:0] resp_tag_o;
    logic             busy_o;

    modport slave (
        input  req_valid_i, req_amo_op_i, req_is_w_i, req_word_hi_i, req_src_i, req_tag_i,
               rd_req_ready_i, rd_resp_valid_i, rd_resp_data_i, alu_result_i, wr_ready_i, resp_ready_i,
        output req_ready_o, rd_req_valid_o, alu_opcode_o, alu_op_w_o, alu_operand0_o, alu_operand1_o,
               wr_valid_o, wr_data_o, wr_mask_o, resp_valid_o, resp_data_o, resp_tag_o, busy_o
    );

    modport master (
        output req_valid_i, req_amo_op_i, req_is_w_i, req_word_hi_i, req_src_i, req_tag_i,
               rd_req_ready_i, rd_resp_valid_i, rd_resp_data_i, alu_result_i, wr_ready_i, resp_ready_i,
        input  req_ready_o, rd_req_valid_o, alu_opcode_o, alu_op_w_o, alu_operand0_o, alu_operand1_o,
               wr_valid_o, wr_data_o, wr_mask_o, resp_valid_o, resp_data_o, resp_tag_o, busy_o
    );
endinterface

// File: rtl/rvh_l1d_amo_ctrl.sv
// rvh_l1d_amo_ctrl: single-outstanding AMO sequencer; reads the doubleword, computes via the L1D ALU,
// writes back the merged value with a byte mask, then returns the old value.
module rvh_l1d_amo_ctrl #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
) (
    input logic clk,
    input logic rst,
    rvh_l1d_amo_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, CALC, WR, RESP} state_e;
    localparam logic [3:0] OP_SWAP = 4'd0, OP_ADD = 4'd1, OP_XOR = 4'd2, OP_AND = 4'd3, OP_OR = 4'd4,
                           OP_MIN = 4'd5, OP_MAX = 4'd6, OP_MINU = 4'd7, OP_MAXU = 4'd8;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic             is_w_q, is_w_d, hi_q, hi_d;
    logic [XLEN-1:0]  src_q, src_d, old_q, old_d, new_q, new_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             lt;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] w);
        return {{(XLEN-32){w[31]}}, w};
    endfunction

    assign lt = bus.alu_result_i[0];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        is_w_d  = is_w_q;
        hi_d    = hi_q;
        src_d   = src_q;
        tag_d   = tag_q;
        old_d   = old_q;
        new_d   = new_q;
        case (state_q)
            IDLE: if (bus.req_valid_i) begin
                op_d    = bus.req_amo_op_i;
                is_w_d  = bus.req_is_w_i;
                hi_d    = bus.req_word_hi_i;
                src_d   = bus.req_is_w_i ? sext32(bus.req_src_i[31:0]) : bus.req_src_i;
                tag_d   = bus.req_tag_i;
                state_d = RD_REQ;
            end
            RD_REQ: if (bus.rd_req_ready_i) state_d = RD_WAIT;
            RD_WAIT: if (bus.rd_resp_valid_i) begin
                old_d   = !is_w_q ? bus.rd_resp_data_i
                        : sext32(hi_q ? bus.rd_resp_data_i[63:32] : bus.rd_resp_data_i[31:0]);
                state_d = CALC;
            end
            CALC: begin
                // SLT/SLTU result bit 0 selects between the two candidates for min/max
                new_d   = (op_q == OP_SWAP) ? src_q
                        : (op_q == OP_MIN || op_q == OP_MINU) ? (lt ? old_q : src_q)
                        : (op_q == OP_MAX || op_q == OP_MAXU) ? (lt ? src_q : old_q)
                        : bus.alu_result_i;
                state_d = WR;
            end
            WR: if (bus.wr_ready_i) state_d = RESP;
            RESP: if (bus.resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            is_w_q  <= 1'b0;
            hi_q    <= 1'b0;
            src_q   <= '0;
            tag_q   <= '0;
            old_q   <= '0;
            new_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            is_w_q  <= is_w_d;
            hi_q    <= hi_d;
            src_q   <= src_d;
            tag_q   <= tag_d;
            old_q   <= old_d;
            new_q   <= new_d;
        end
    end

    assign bus.req_ready_o    = state_q == IDLE;
    assign bus.busy_o         = state_q != IDLE;
    assign bus.rd_req_valid_o = state_q == RD_REQ;
    assign bus.wr_valid_o     = state_q == WR;
    assign bus.resp_valid_o   = state_q == RESP;
    assign bus.alu_opcode_o   = (op_q == OP_XOR) ? 4'd5
                              : (op_q == OP_AND) ? 4'd9
                              : (op_q == OP_OR) ? 4'd8
                              : (op_q == OP_MIN || op_q == OP_MAX) ? 4'd3
                              : (op_q == OP_MINU || op_q == OP_MAXU) ? 4'd4 : 4'd0;
    // Compares always run 64-bit so sign-extended words order correctly for signed and unsigned
    assign bus.alu_op_w_o     = state_q == CALC && op_q == OP_ADD && is_w_q;
    assign bus.alu_operand0_o = old_q;
    assign bus.alu_operand1_o = src_q;
    assign bus.wr_data_o      = is_w_q ? {2{new_q[31:0]}} : new_q;
    assign bus.wr_mask_o      = state_q != WR ? 8'h00 : !is_w_q ? 8'hFF : hi_q ? 8'hF0 : 8'h0F;
    assign bus.resp_data_o    = old_q;
    assign bus.resp_tag_o     = tag_q;

    a_legal_op: assert property (@(posedge clk) disable iff (rst)
        bus.req_valid_i && bus.req_ready_o |-> bus.req_amo_op_i <= OP_MAXU);
endmodule

// File: tb/tb_rvh_l1d_amo_ctrl.sv
// tb_rvh_l1d_amo_ctrl: directed and randomized AMO transactions checked against a word-level reference model.
module tb_rvh_l1d_amo_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    rvh_l1d_amo_ctrl_if bus ();
    rvh_l1d_amo_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    bit          alu_junk = 1'b0;
    logic [63:0] junk_val = 64'h5A5A_F00D_1234_9876;
    logic [63:0] alu_r;
    logic [31:0] alu_s32;
    always_comb begin
        alu_s32 = bus.alu_operand0_o[31:0] + bus.alu_operand1_o[31:0];
        case (bus.alu_opcode_o)
            4'd0: alu_r = bus.alu_op_w_o ? {{32{alu_s32[31]}}, alu_s32} : bus.alu_operand0_o + bus.alu_operand1_o;
            4'd3: alu_r = {63'd0, $signed(bus.alu_operand0_o) < $signed(bus.alu_operand1_o)};
            4'd4: alu_r = {63'd0, bus.alu_operand0_o < bus.alu_operand1_o};
            4'd5: alu_r = bus.alu_operand0_o ^ bus.alu_operand1_o;
            4'd8: alu_r = bus.alu_operand0_o | bus.alu_operand1_o;
            4'd9: alu_r = bus.alu_operand0_o & bus.alu_operand1_o;
            default: alu_r = 64'd0;
        endcase
        bus.alu_result_i = alu_r ^ (alu_junk ? junk_val : 64'd0);
    end

    logic [3:0] opc_tab [9] = '{4'd0, 4'd0, 4'd5, 4'd9, 4'd8, 4'd3, 4'd3, 4'd4, 4'd4};

    // Reference: operate on the architectural word/doubleword values directly
    function automatic void ref_amo(input logic [3:0] op, input logic w, input logic hi, input logic [63:0] src,
                                    input logic [63:0] d, output logic [63:0] wd, output logic [7:0] wm,
                                    output logic [63:0] old);
        longint so, ss;
        longint unsigned nv;
        logic [31:0] ow;
        bit slt, ult;
        ow  = hi ? d[63:32] : d[31:0];
        so  = w ? longint'(int'(ow)) : longint'(d);
        ss  = w ? longint'(int'(src[31:0])) : longint'(src);
        slt = so < ss;
        ult = w ? (ow < src[31:0]) : (d < src);
        case (op)
            4'd0: nv = ss;
            4'd1: nv = so + ss;
            4'd2: nv = so ^ ss;
            4'd3: nv = so & ss;
            4'd4: nv = so | ss;
            4'd5: nv = slt ? so : ss;
            4'd6: nv = slt ? ss : so;
            4'd7: nv = ult ? so : ss;
            4'd8: nv = ult ? ss : so;
            default: nv = 64'd0;
        endcase
        old = so;
        wd  = w ? {nv[31:0], nv[31:0]} : nv;
        wm  = !w ? 8'hFF : hi ? 8'hF0 : 8'h0F;
    endfunction

    logic [63:0] o_wd, o_rd, e_wd, e_old;
    logic [7:0]  o_wm, o_tag, e_wm;
    logic [3:0]  o_opc;
    logic        o_opw;
    int          o_lat, o_wrn;
    bit          o_stable, o_rdybad, o_order, o_idle;

    task automatic do_amo(input logic [3:0] op, input logic w, input logic hi, input logic [63:0] src,
                          input logic [7:0] tag, input logic [63:0] rdd, input int rd_st, input int rd_lat,
                          input int wr_st, input int rs_st, input bit junk);
        int lat, rd_cnt;
        bit calc, resp_done, wr_first, rs_first;
        bus.req_valid_i = 1'b1; bus.req_amo_op_i = op; bus.req_is_w_i = w; bus.req_word_hi_i = hi;
        bus.req_src_i = src; bus.req_tag_i = tag;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0; bus.req_amo_op_i = 4'($urandom_range(0, 8)); bus.req_is_w_i = ~w;
        bus.req_word_hi_i = ~hi; bus.req_src_i = {$urandom, $urandom}; bus.req_tag_i = ~tag;
        lat = 1; rd_cnt = -1; calc = 0; resp_done = 0; wr_first = 1; rs_first = 1;
        o_lat = -1; o_wrn = 0; o_stable = 1; o_rdybad = 0; o_order = 0; o_opc = 4'hF; o_opw = 1'b1;
        o_wd = '0; o_wm = '0; o_rd = '0; o_tag = '0;
        while (!resp_done && lat < 60) begin
            bus.rd_req_ready_i = 1'b0; bus.wr_ready_i = 1'b0; bus.resp_ready_i = 1'b0;
            bus.rd_resp_data_i = {$urandom, $urandom};
            bus.rd_resp_valid_i = junk && rd_cnt <= 0 && $urandom_range(0, 1) == 1;
            if (calc) begin o_opc = bus.alu_opcode_o; o_opw = bus.alu_op_w_o; end
            calc = 0;
            if (bus.req_ready_o) o_rdybad = 1;
            if (rd_cnt > 0) begin
                rd_cnt--;
                bus.rd_resp_valid_i = rd_cnt == 0;
                bus.rd_resp_data_i = rdd;
                calc = rd_cnt == 0;
            end else if (bus.rd_req_valid_o && rd_cnt < 0) begin
                if (rd_st > 0) rd_st--;
                else begin bus.rd_req_ready_i = 1'b1; rd_cnt = rd_lat; end
            end
            if (bus.resp_valid_o) begin
                if (o_wrn == 0) o_order = 1;
                if (rs_first) begin o_rd = bus.resp_data_o; o_tag = bus.resp_tag_o; rs_first = 0; end
                else if (bus.resp_data_o !== o_rd || bus.resp_tag_o !== o_tag) o_stable = 0;
                if (rs_st > 0) rs_st--;
                else begin bus.resp_ready_i = 1'b1; resp_done = 1; o_lat = lat; end
            end
            if (bus.wr_valid_o) begin
                if (wr_first) begin o_wd = bus.wr_data_o; o_wm = bus.wr_mask_o; wr_first = 0; end
                else if (bus.wr_data_o !== o_wd || bus.wr_mask_o !== o_wm) o_stable = 0;
                if (wr_st > 0) wr_st--;
                else begin bus.wr_ready_i = 1'b1; o_wrn++; end
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.rd_req_ready_i = 1'b0; bus.rd_resp_valid_i = 1'b0; bus.wr_ready_i = 1'b0; bus.resp_ready_i = 1'b0;
        o_idle = bus.req_ready_o && !bus.resp_valid_o && !bus.busy_o;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if ({bus.req_ready_o, bus.busy_o, bus.rd_req_valid_o, bus.wr_valid_o, bus.resp_valid_o} !== 5'b10000) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=10000", {bus.req_ready_o, bus.busy_o, bus.rd_req_valid_o, bus.wr_valid_o, bus.resp_valid_o}); end
        total++; if ({bus.wr_data_o, bus.wr_mask_o, bus.resp_data_o, bus.resp_tag_o} !== 144'd0) begin
            bad++; $display("FAIL reset_data wd=%h wm=%h rd=%h tag=%h exp=0", bus.wr_data_o, bus.wr_mask_o, bus.resp_data_o, bus.resp_tag_o); end
        total++; if ({bus.alu_opcode_o, bus.alu_op_w_o, bus.alu_operand0_o, bus.alu_operand1_o} !== 133'd0) begin
            bad++; $display("FAIL reset_alu opc=%0d w=%b a=%h b=%h exp=0", bus.alu_opcode_o, bus.alu_op_w_o, bus.alu_operand0_o, bus.alu_operand1_o); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", bus.req_ready_o); end
    endtask

    task automatic test_amoadd_d();
        do_amo(4'd1, 1'b0, 1'b0, 64'd1, 8'hA1, 64'h0000_0000_FFFF_FFFF, 0, 1, 0, 0, 1'b0);
        total++; if (o_wd !== 64'h0000_0001_0000_0000) begin bad++; $display("FAIL add_d_wdata got=%h exp=0000000100000000", o_wd); end
        total++; if (o_wm !== 8'hFF) begin bad++; $display("FAIL add_d_mask got=%h exp=ff", o_wm); end
        total++; if (o_rd !== 64'h0000_0000_FFFF_FFFF) begin bad++; $display("FAIL add_d_resp got=%h exp=00000000ffffffff", o_rd); end
        total++; if (o_tag !== 8'hA1) begin bad++; $display("FAIL add_d_tag got=%h exp=a1", o_tag); end
        total++; if (o_lat !== 5) begin bad++; $display("FAIL add_d_latency got=%0d exp=5", o_lat); end
        total++; if ({o_opc, o_opw} !== 5'b0000_0) begin bad++; $display("FAIL add_d_alu opc=%0d w=%b exp=0/0", o_opc, o_opw); end
    endtask

    task automatic test_amoadd_w_hi();
        do_amo(4'd1, 1'b1, 1'b1, 64'd1, 8'h17, 64'h7FFF_FFFF_0000_0005, 0, 1, 0, 0, 1'b0);
        total++; if (o_wd[63:32] !== 32'h8000_0000) begin bad++; $display("FAIL add_w_hi_wdata got=%h exp=80000000", o_wd[63:32]); end
        total++; if (o_wm !== 8'hF0) begin bad++; $display("FAIL add_w_hi_mask got=%h exp=f0", o_wm); end
        total++; if (o_rd !== 64'h0000_0000_7FFF_FFFF) begin bad++; $display("FAIL add_w_hi_resp got=%h exp=000000007fffffff", o_rd); end
        total++; if (o_opw !== 1'b1) begin bad++; $display("FAIL add_w_hi_opw got=%b exp=1", o_opw); end
    endtask

    task automatic test_min_minu_w();
        do_amo(4'd5, 1'b1, 1'b0, 64'd1, 8'h01, 64'hDEAD_BEEF_FFFF_FFFF, 0, 1, 0, 0, 1'b0);
        total++; if (o_wd !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL min_w_wdata got=%h exp=ffffffffffffffff", o_wd); end
        total++; if ({o_opc, o_opw} !== {4'd3, 1'b0}) begin bad++; $display("FAIL min_w_opcode got=%0d/%b exp=3/0", o_opc, o_opw); end
        total++; if ({o_wm, o_rd} !== {8'h0F, 64'hFFFF_FFFF_FFFF_FFFF}) begin bad++; $display("FAIL min_w_mask_resp got=%h/%h exp=0f/ffffffffffffffff", o_wm, o_rd); end
        do_amo(4'd7, 1'b1, 1'b0, 64'd1, 8'h02, 64'hDEAD_BEEF_FFFF_FFFF, 0, 1, 0, 0, 1'b0);
        total++; if (o_wd[31:0] !== 32'h0000_0001) begin bad++; $display("FAIL minu_w_wdata got=%h exp=00000001", o_wd[31:0]); end
        total++; if ({o_opc, o_opw} !== {4'd4, 1'b0}) begin bad++; $display("FAIL minu_w_opcode got=%0d/%b exp=4/0", o_opc, o_opw); end
    endtask

    task automatic test_max_swap_d();
        do_amo(4'd6, 1'b0, 1'b0, 64'd0, 8'h03, 64'h8000_0000_0000_0000, 0, 1, 0, 0, 1'b0);
        total++; if ({o_wd, o_wm} !== {64'd0, 8'hFF}) begin bad++; $display("FAIL max_d got=%h/%h exp=0/ff", o_wd, o_wm); end
        alu_junk = 1'b1;
        do_amo(4'd0, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 8'h04, 64'hFEDC_BA98_7654_3210, 0, 1, 0, 0, 1'b0);
        alu_junk = 1'b0;
        total++; if (o_wd !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL swap_d_wdata got=%h exp=0123456789abcdef", o_wd); end
        total++; if (o_rd !== 64'hFEDC_BA98_7654_3210) begin bad++; $display("FAIL swap_d_resp got=%h exp=fedcba9876543210", o_rd); end
    endtask

    task automatic test_backpressure();
        do_amo(4'd2, 1'b0, 1'b0, 64'h00FF_00FF_00FF_00FF, 8'h99, 64'h0F0F_0F0F_0F0F_0F0F, 3, 1, 2, 4, 1'b1);
        total++; if (o_lat !== 14) begin bad++; $display("FAIL bp_latency got=%0d exp=14", o_lat); end
        total++; if ({o_stable, o_rdybad, o_order} !== 3'b100) begin bad++; $display("FAIL bp_stable_ready got=%b exp=100", {o_stable, o_rdybad, o_order}); end
        total++; if ({o_wd, o_rd} !== {64'h0FF0_0FF0_0FF0_0FF0, 64'h0F0F_0F0F_0F0F_0F0F}) begin bad++; $display("FAIL bp_data got=%h/%h exp=0ff00ff00ff00ff0/0f0f0f0f0f0f0f0f", o_wd, o_rd); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        bus.req_valid_i = 1'b1; bus.req_amo_op_i = 4'd1; bus.req_is_w_i = 1'b0; bus.req_word_hi_i = 1'b0;
        bus.req_src_i = 64'd7; bus.req_tag_i = 8'h5A;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0; bus.rd_req_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rd_req_ready_i = 1'b0; bus.rd_resp_valid_i = 1'b1; bus.rd_resp_data_i = 64'd100;
        @(posedge clk); #1;
        bus.rd_resp_valid_i = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.wr_valid_o !== 1'b1) begin bad++; $display("FAIL rstmid_in_wr got=%b exp=1", bus.wr_valid_o); end
        #2 rst = 1'b1;
        #1;
        total++; if ({bus.wr_valid_o, bus.busy_o, bus.req_ready_o} !== 3'b001) begin bad++; $display("FAIL rstmid_drop got=%b exp=001", {bus.wr_valid_o, bus.busy_o, bus.req_ready_o}); end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.wr_ready_i = 1'b1; bus.resp_ready_i = 1'b1; seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid_o || bus.wr_valid_o) seen = 1;
        end
        bus.wr_ready_i = 1'b0; bus.resp_ready_i = 1'b0;
        total++; if (seen) begin bad++; $display("FAIL rstmid_no_resp got=1 exp=0"); end
        do_amo(4'd1, 1'b0, 1'b0, 64'd7, 8'h33, 64'd100, 0, 1, 0, 0, 1'b0);
        total++; if ({o_wd, o_rd, o_tag} !== {64'd107, 64'd100, 8'h33}) begin bad++; $display("FAIL rstmid_next got=%0d/%0d/%h exp=107/100/33", o_wd, o_rd, o_tag); end
        total++; if (o_lat !== 5) begin bad++; $display("FAIL rstmid_next_latency got=%0d exp=5", o_lat); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] op;
        logic w, hi, jk;
        logic [63:0] src, d;
        logic [7:0] tag;
        int rs, rl, ws, ps;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 8)); w = 1'($urandom_range(0, 1)); hi = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom};
            src = ($urandom_range(0, 3) == 0) ? d : {$urandom, $urandom};
            tag = 8'($urandom); jk = 1'($urandom_range(0, 1));
            rs = $urandom_range(0, 2); rl = $urandom_range(1, 3); ws = $urandom_range(0, 2); ps = $urandom_range(0, 2);
            do_amo(op, w, hi, src, tag, d, rs, rl, ws, ps, jk);
            ref_amo(op, w, hi, src, d, e_wd, e_wm, e_old);
            total++; if (o_wd !== e_wd) begin bad++; $display("FAIL rand_wdata i=%0d op=%0d w=%b got=%h exp=%h", i, op, w, o_wd, e_wd); end
            total++; if (o_wm !== e_wm) begin bad++; $display("FAIL rand_mask i=%0d got=%h exp=%h", i, o_wm, e_wm); end
            total++; if ({o_rd, o_tag} !== {e_old, tag}) begin bad++; $display("FAIL rand_resp i=%0d got=%h/%h exp=%h/%h", i, o_rd, o_tag, e_old, tag); end
            total++; if (o_lat !== 5 + rs + rl - 1 + ws + ps) begin bad++; $display("FAIL rand_latency i=%0d got=%0d exp=%0d", i, o_lat, 5 + rs + rl - 1 + ws + ps); end
            total++; if ({o_stable, o_rdybad, o_order, o_wrn == 1, o_idle} !== 5'b10011) begin bad++; $display("FAIL rand_protocol i=%0d got=%b exp=10011", i, {o_stable, o_rdybad, o_order, o_wrn == 1, o_idle}); end
            if (op != 4'd0) begin
                total++; if ({o_opc, o_opw} !== {opc_tab[op], w && op == 4'd1}) begin bad++; $display("FAIL rand_alu i=%0d op=%0d got=%0d/%b exp=%0d/%b", i, op, o_opc, o_opw, opc_tab[op], w && op == 4'd1); end
            end
        end
    endtask

    initial begin
        bus.req_valid_i = 1'b0; bus.req_amo_op_i = '0; bus.req_is_w_i = 1'b0; bus.req_word_hi_i = 1'b0;
        bus.req_src_i = '0; bus.req_tag_i = '0; bus.rd_req_ready_i = 1'b0; bus.rd_resp_valid_i = 1'b0;
        bus.rd_resp_data_i = '0; bus.wr_ready_i = 1'b0; bus.resp_ready_i = 1'b0;
        test_reset();
        test_amoadd_d();
        test_amoadd_w_hi();
        test_min_minu_w();
        test_max_swap_d();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
